// File: rtl/cp0_regfile_pkg.sv
// cp0_regfile_pkg: shared constants for the CP0 register file.
//   - CP0 register numbers used by mtc0/mfc0 decode
//   - exception-type codes from the M-stage classifier and the ExcCode values
//   - Status/Cause bit positions, write masks and reset value
//   - helpers that classify an exception-type code
package cp0_regfile_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;

    // Exception-type codes delivered by the classifier
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0A;
    localparam logic [4:0] EXCCODE_OV   = 5'h0C;

    // Status fields
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_IM_HI  = 15;
    localparam int STATUS_BEV    = 22;

    // Cause fields
    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_IPSW_LO  = 8;
    localparam int CAUSE_IPSW_HI  = 9;
    localparam int CAUSE_IPHW_LO  = 10;
    localparam int CAUSE_IPHW_HI  = 15;
    localparam int CAUSE_BD       = 31;

    // Bits software may change through mtc0
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // True for codes that take an exception (eret is handled separately).
    function automatic logic is_exception(input logic [31:0] code);
        logic hit;
        hit = 1'b0;
        case (code)
            EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
            EXC_BP, EXC_RI, EXC_OV:  hit = 1'b1;
            default:                 hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Interrupts report ExcCode 0; every other code reports its own low bits.
    function automatic logic [4:0] exc_code(input logic [31:0] code);
        return (code == EXC_INT) ? EXCCODE_INT : code[4:0];
    endfunction

    function automatic logic is_addr_error(input logic [31:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: Count/Compare timer for CP0.
//   Count advances once every two clocks via an internal tick; a Count write
//   reloads it and restarts the half-rate phase. timer_int_o latches the
//   cycle after Count==Compare (Compare nonzero) and stays set until the
//   next Compare write.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   count_we_i      load Count from wdata_i
//   compare_we_i    load Compare from wdata_i, clears the interrupt
//   wdata_i         write data
//   count_o         current Count
//   compare_o       current Compare
//   timer_int_o     pending timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;
    logic        timer_q, timer_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        timer_d   = timer_q;

        // A Count write overrides the increment and restarts the phase.
        if (count_we_i) begin
            count_d = wdata_i;
            tick_d  = 1'b0;
        end

        if (compare_we_i) begin
            compare_d = wdata_i;
        end

        // Clearing by Compare write takes priority over a coincident match.
        if (compare_we_i) begin
            timer_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tick_q    <= 1'b0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file at the MEM/WB boundary.
//   Holds BadVAddr/Count/Compare/Status/Cause/EPC, services mtc0/mfc0,
//   records exceptions from the M-stage classifier and produces the
//   pipeline flush and redirect PC.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   we_i/waddr_i/data_i   mtc0 write
//   raddr_i/data_o        mfc0 read (combinational)
//   int_i                 external hardware interrupt lines
//   excepttype_i          prioritised exception code
//   pc_i                  M-stage PC
//   is_in_delayslot_i     M-stage instruction sits in a delay slot
//   bad_addr_i            faulting address for AdEL/AdES
//   *_o register outputs  current register contents
//   timer_int_o           pending timer interrupt
//   flush_o, newpc_o      pipeline flush and redirect target
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic mtc0_en;
    logic exc_take;
    logic is_eret;

    // Any exception activity in M cancels the mtc0 in the same slot.
    assign mtc0_en  = we_i && (excepttype_i == EXC_NONE);
    assign exc_take = is_exception(excepttype_i);
    assign is_eret  = (excepttype_i == EXC_ERET);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0_en && (waddr_i == CP0_COUNT)),
        .compare_we_i (mtc0_en && (waddr_i == CP0_COMPARE)),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        if (mtc0_en) begin
            case (waddr_i)
                CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                CP0_CAUSE:  cause_d  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
                CP0_EPC:    epc_d    = data_i;
                default:    ;
            endcase
        end

        // Hardware pending bits track the lines every cycle; the timer shares IP7.
        cause_d[CAUSE_IPHW_HI:CAUSE_IPHW_LO] = {int_i[5] | timer_int_o, int_i[4:0]};

        if (exc_take) begin
            // A nested exception (EXL already set) keeps the original return point.
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL]                = 1'b1;
            cause_d[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_code(excepttype_i);
            if (is_addr_error(excepttype_i)) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (is_eret) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_q;
            CP0_EPC:      data_o = epc_q;
            CP0_PRID:     data_o = PRID_VAL;
            CP0_CONFIG:   data_o = 32'd0;
            default:      data_o = 32'd0;
        endcase
    end

    assign flush_o = (excepttype_i != EXC_NONE);

    always_comb begin
        newpc_o = 32'd0;
        if (is_eret) begin
            newpc_o = epc_q;
        end else if (excepttype_i != EXC_NONE) begin
            newpc_o = EXC_VECTOR;
        end
    end

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] bad_addr_i;
    logic [31:0] data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o, flush_o;
    logic [31:0] newpc_o;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .we_i              (we_i),
        .waddr_i           (waddr_i),
        .raddr_i           (raddr_i),
        .data_i            (data_i),
        .int_i             (int_i),
        .excepttype_i      (excepttype_i),
        .pc_i              (pc_i),
        .is_in_delayslot_i (is_in_delayslot_i),
        .bad_addr_i        (bad_addr_i),
        .data_o            (data_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .badvaddr_o        (badvaddr_o),
        .timer_int_o       (timer_int_o),
        .flush_o           (flush_o),
        .newpc_o           (newpc_o)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model, kept as separate architectural fields.
    logic [31:0] m_base;        // Count value at last load/reset
    int unsigned m_edges;       // clock edges since that load
    logic [31:0] m_compare;
    logic        m_timer;
    logic [7:0]  m_im;
    logic        m_exl, m_ie;
    logic        m_bd;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exccode;
    logic [31:0] m_epc, m_bad;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_edges / 2);
    endfunction
    function automatic logic [31:0] m_status();
        return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction
    function automatic logic [31:0] m_cause();
        return {m_bd, 15'b0, m_ip_hw, m_ip_sw, 1'b0, m_exccode, 2'b0};
    endfunction
    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd8:  return m_bad;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return m_status();
            5'd13: return m_cause();
            5'd14: return m_epc;
            5'd15: return 32'h0000_4220;
            default: return 32'd0;
        endcase
    endfunction
    function automatic logic m_is_exc(input logic [31:0] c);
        return (c == 1) || (c == 4) || (c == 5) || (c == 8) || (c == 9) || (c == 10) || (c == 12);
    endfunction

    always @(posedge clk) begin
        logic        mtc;
        logic [31:0] cur;
        if (rst) begin
            m_base <= 0; m_edges <= 0; m_compare <= 0; m_timer <= 0;
            m_im <= 0; m_exl <= 0; m_ie <= 0;
            m_bd <= 0; m_ip_hw <= 0; m_ip_sw <= 0; m_exccode <= 0;
            m_epc <= 0; m_bad <= 0;
        end else begin
            mtc = we_i && (excepttype_i == 0);
            cur = m_count();
            m_ip_hw <= {int_i[5] | m_timer, int_i[4:0]};
            if (mtc && waddr_i == 11)                      m_timer <= 1'b0;
            else if (cur == m_compare && m_compare != 0)   m_timer <= 1'b1;
            if (mtc && waddr_i == 9) begin
                m_base  <= data_i;
                m_edges <= 0;
            end else begin
                m_edges <= m_edges + 1;
            end
            if (mtc) begin
                case (waddr_i)
                    5'd11: m_compare <= data_i;
                    5'd12: begin m_im <= data_i[15:8]; m_exl <= data_i[1]; m_ie <= data_i[0]; end
                    5'd13: m_ip_sw <= data_i[9:8];
                    5'd14: m_epc <= data_i;
                    default: ;
                endcase
            end
            if (m_is_exc(excepttype_i)) begin
                if (!m_exl) begin
                    m_epc <= is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    m_bd  <= is_in_delayslot_i;
                end
                m_exl     <= 1'b1;
                m_exccode <= (excepttype_i == 1) ? 5'd0 : excepttype_i[4:0];
                if (excepttype_i == 4 || excepttype_i == 5) m_bad <= bad_addr_i;
            end else if (excepttype_i == 32'hE) begin
                m_exl <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("status", status_o, m_status());
            chk("cause", cause_o, m_cause());
            chk("epc", epc_o, m_epc);
            chk("count", count_o, m_count());
            chk("compare", compare_o, m_compare);
            chk("badvaddr", badvaddr_o, m_bad);
            chk("timer_int", {31'b0, timer_int_o}, {31'b0, m_timer});
            chk("data_o", data_o, m_read(raddr_i));
            chk("flush", {31'b0, flush_o}, {31'b0, excepttype_i != 0});
            chk("newpc", newpc_o, (excepttype_i == 32'hE) ? m_epc :
                                  (excepttype_i != 0) ? 32'hBFC0_0380 : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 0; waddr_i = 0; data_i = 0; excepttype_i = 0;
        pc_i = 0; is_in_delayslot_i = 0; bad_addr_i = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        we_i = 1; waddr_i = r; data_i = d;
        cyc();
        we_i = 0;
    endtask

    initial begin
        bit seen;
        rst = 1; raddr_i = 0; int_i = 0;
        idle_inputs();
        cyc(); cyc();
        rst = 0;
        chk_en = 1;
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_count", count_o, 32'd0);
        chk("rst_flush", {31'b0, flush_o}, 32'd0);
        repeat (10) cyc();
        chk("idle_count", count_o, 32'd5);

        // Timer from reset
        rst = 1; cyc(); rst = 0;
        mtc0(5'd11, 32'd3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (timer_int_o) seen = 1;
            else cyc();
        end
        chk("timer_set", {31'b0, timer_int_o}, 32'd1);
        chk("timer_count", count_o, 32'd3);
        cyc();
        chk("cause_ip7", {31'b0, cause_o[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("timer_clr", {31'b0, timer_int_o}, 32'd0);

        // Overflow in delay slot
        excepttype_i = 32'hC; pc_i = 32'h8000_0100; is_in_delayslot_i = 1;
        #1;
        chk("ov_flush", {31'b0, flush_o}, 32'd1);
        chk("ov_newpc", newpc_o, 32'hBFC0_0380);
        cyc(); idle_inputs();
        chk("ov_epc", epc_o, 32'h8000_00FC);
        chk("ov_bd", {31'b0, cause_o[31]}, 32'd1);
        chk("ov_code", {27'b0, cause_o[6:2]}, 32'd12);
        chk("ov_exl", {31'b0, status_o[1]}, 32'd1);

        // AdEL while EXL=1
        excepttype_i = 32'h4; bad_addr_i = 32'h8000_0003; pc_i = 32'h8000_0200;
        cyc(); idle_inputs();
        chk("adel_bad", badvaddr_o, 32'h8000_0003);
        chk("adel_code", {27'b0, cause_o[6:2]}, 32'd4);
        chk("adel_epc_kept", epc_o, 32'h8000_00FC);

        // eret
        mtc0(5'd14, 32'h8000_1000);
        excepttype_i = 32'hE;
        #1;
        chk("eret_newpc", newpc_o, 32'h8000_1000);
        cyc(); idle_inputs();
        chk("eret_exl", {31'b0, status_o[1]}, 32'd0);

        // Status write mask, then mtc0 dropped by exception
        mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status_o, 32'h0040_FF03);
        we_i = 1; waddr_i = 5'd14; data_i = 32'h1234_5678;
        excepttype_i = 32'h8; pc_i = 32'h8000_0400;
        cyc(); idle_inputs();
        chk("drop_epc", epc_o, 32'h8000_1000);
        chk("sys_code", {27'b0, cause_o[6:2]}, 32'd8);

        // Cause write only touches IP[9:8]
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_sw", {30'b0, cause_o[9:8]}, 32'd3);

        // mfc0 reads
        raddr_i = 5'd15; #1; chk("prid", data_o, 32'h0000_4220);
        raddr_i = 5'd16; #1; chk("config", data_o, 32'd0);
        raddr_i = 5'd3;  #1; chk("unimpl", data_o, 32'd0);
        raddr_i = 5'd12; #1; chk("rd_status", data_o, 32'h0040_FF03);

        // Count load and wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        chk("cnt_load", count_o, 32'hFFFF_FFFF);
        cyc(); cyc();
        chk("cnt_wrap", count_o, 32'd0);

        // Hardware interrupt lines
        int_i = 6'b000001;
        cyc();
        chk("ip_hw", {26'b0, cause_o[15:10]}, 32'd1);
        int_i = 0;

        // Unrecognised code: flush only, mtc0 dropped
        we_i = 1; waddr_i = 5'd14; data_i = 32'hDEAD_BEEF; excepttype_i = 32'h3;
        #1;
        chk("unk_flush", {31'b0, flush_o}, 32'd1);
        cyc(); idle_inputs();
        chk("unk_epc", epc_o, 32'h8000_1000);

        // Reset mid-operation with conflicting inputs
        rst = 1; we_i = 1; waddr_i = 5'd14; data_i = 32'h5555_5555;
        excepttype_i = 32'hC; pc_i = 32'h8000_0800;
        cyc();
        rst = 0; idle_inputs();
        chk("mrst_status", status_o, 32'h0040_0000);
        chk("mrst_epc", epc_o, 32'd0);
        chk("mrst_cause", cause_o, 32'd0);
        repeat (4) cyc();

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- MIPS CP0 register file at the MEM/WB boundary.
- Consumes the prioritised 32-bit exception code and faulting address produced by the M-stage exception classifier.
- Maintains BadVAddr/Count/Compare/Status/Cause/EPC and the timer interrupt.
- Services mtc0/mfc0 and drives pipeline flush plus redirect PC on exception or eret.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions and interrupts.
- PRID_VAL, 32'h00004220, read-only PRId (reg 15) value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- we_i  in  1  mtc0 write enable
- waddr_i  in  5  mtc0 register number
- raddr_i  in  5  mfc0 register number
- data_i  in  32  mtc0 write data
- int_i  in  6  external hardware interrupt lines
- excepttype_i  in  32  exception code: 0 none, 1 int, 4 AdEL, 5 AdES, 8 sys, 9 bp, a RI, c Ov, e eret
- pc_i  in  32  M-stage instruction PC
- is_in_delayslot_i  in  1  M-stage instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address, valid for codes 4/5
- data_o  out  32  mfc0 read data
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  register contents
- timer_int_o  out  1  Count==Compare pending
- flush_o  out  1  flush pipeline
- newpc_o  out  32  redirect target

Behaviour:
- Reset values:
  - Status = 32'h00400000 (BEV=1).
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - timer_int_o = 0; internal tick = 0.
- Count increments once every two clk cycles (tick toggles each cycle; Count+1 when tick==1). Count wraps 32'hFFFFFFFF -> 0 with no flag.
- Timer: timer_int_o set the cycle after Count==Compare with Compare!=0. Held until Compare is written, which clears it the following cycle.
- Cause.IP[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]} every cycle, regardless of exceptions.
- mtc0, registered, applies when we_i=1 and excepttype_i==0:
  - Count (9): loads data_i and clears tick.
  - Compare (11): full write; clears timer_int_o.
  - Status (12): only IM[15:8], EXL[1], IE[0] written; other bits keep their value.
  - Cause (13): only IP[9:8] written.
  - EPC (14): full write.
  - BadVAddr, PRId and unlisted numbers: write ignored.
- mfc0: data_o is combinational from current register state. No same-cycle write forwarding.
  - Reg 15 returns PRID_VAL; reg 16 returns 0.
  - Any other unimplemented number returns 0.
- Exception, excepttype_i in {1,4,5,8,9,a,c}, applied at clk edge:
  - If Status.EXL==0: EPC <= is_in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD <= is_in_delayslot_i.
  - If Status.EXL==1: EPC and BD unchanged.
  - Status.EXL <= 1.
  - Cause.ExcCode[6:2] <= 0 for code 1, otherwise the low 5 bits of the code.
  - Codes 4/5 only: BadVAddr <= bad_addr_i.
- eret (excepttype_i == e): Status.EXL <= 0. Nothing else changes.
- flush_o is combinational and is 1 whenever excepttype_i != 0.
- newpc_o:
  - eret: epc_o, the current registered EPC.
  - Any other exception: EXC_VECTOR.
  - No exception: 0.
- Simultaneous events:
  - Exception beats mtc0: the whole write is dropped.
  - Counter tick and a Count write in the same cycle: the write wins.
  - Compare write and a timer match in the same cycle: the interrupt is cleared.
- Any unrecognised nonzero excepttype_i is treated as no exception for register updates, but flush_o still asserts.
- Reset mid-operation restores all reset values on the next edge regardless of other inputs.

Decomposition:
- Shared package holds:
  - CP0 register numbers: BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14, PRID=15, CONFIG=16.
  - Excepttype code constants and ExcCode values.
  - Status/Cause bit-field positions.
  - Status/Cause write masks.
- Natural sub-module: cp0_timer (Count, tick, Compare, timer_int_o), instantiated once.

Test Plan:
- Reset, then idle 10 cycles -> Count=5, Status=32'h00400000, flush_o=0.
- Write Compare=3 from reset -> timer_int_o=1 the cycle after Count==3; Cause[15]=1. Rewrite Compare -> timer_int_o=0.
- excepttype_i=c, pc_i=32'h80000100, delayslot=1 -> EPC=32'h800000FC, Cause.BD=1, ExcCode=12, EXL=1, flush_o=1, newpc_o=32'hBFC00380.
- excepttype_i=4, bad_addr_i=32'h80000003 -> BadVAddr=32'h80000003, ExcCode=4. Second exception with EXL=1 -> EPC unchanged.
- excepttype_i=e with EPC=32'h80001000 -> newpc_o=32'h80001000, EXL=0 after the edge.
- mtc0 Status=32'hFFFFFFFF -> Status=32'h0040FF03. mtc0 EPC issued with excepttype_i=8 in the same cycle -> write dropped, ExcCode=8.
